// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter: FSM states,
// parity encodings and a parity function usable for any character width up to 9.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam int   MAX_DATA_W = 9;

  // Seeding with the parity type turns even parity (^data) into odd (~^data).
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                       input int                    width,
                                       input logic                  par_typ);
    logic p;
    p = (par_typ == PAR_ODD);
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < width) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO using read/write pointers with an extra wrap bit to
// distinguish full from empty; read data is the current head, shown combinationally.
module uart_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count   = r_wptr - r_rptr;
  assign o_rd_data = r_mem[r_rptr[AW-1:0]];
  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_rd_en && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed from an internal FIFO; frames go out back-to-back with
// per-frame latched prescale, parity and stop-bit settings.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [PRESCALE_WIDTH-1:0]     Prescale,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  input  logic [DATA_WIDTH-1:0]         S_DATA,
  input  logic                          S_VALID,
  output logic                          S_READY,
  output logic                          TX_OUT,
  output logic                          Busy,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int                 BW       = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0]      BIT_LAST = BW'(DATA_WIDTH - 1);

  tx_state_t                   r_state;
  logic [PRESCALE_WIDTH-1:0]   r_cnt;
  logic [PRESCALE_WIDTH-1:0]   r_presc;
  logic [BW-1:0]               r_bit_idx;
  logic                        r_stop_idx;
  logic                        r_par_en;
  logic                        r_stop2;
  logic                        r_tx;
  logic                        r_busy;
  logic [DATA_WIDTH-1:0]       r_shift;
  logic                        r_parity;

  logic                        w_full;
  logic                        w_empty;
  logic [DATA_WIDTH-1:0]       w_head;
  logic [MAX_DATA_W-1:0]       w_head_ext;
  logic                        w_bit_end;
  logic                        w_last_stop;
  logic                        w_pop;

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (CLK),
    .i_rst_n   (RST),
    .i_wr_en   (S_VALID),
    .i_wr_data (S_DATA),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (FIFO_COUNT)
  );

  assign S_READY     = !w_full;
  assign TX_OUT      = r_tx;
  assign Busy        = r_busy;
  assign w_bit_end   = (r_cnt == r_presc - PRESCALE_WIDTH'(1));
  assign w_last_stop = !r_stop2 || r_stop_idx;
  assign w_pop       = !w_empty && ((r_state == ST_IDLE) ||
                       (r_state == ST_STOP && w_bit_end && w_last_stop));

  always_comb begin
    w_head_ext = '0;
    w_head_ext[DATA_WIDTH-1:0] = w_head;
  end

  always_ff @(posedge CLK) begin
    if (w_pop) begin
      r_shift  <= w_head;
      r_parity <= calc_parity(w_head_ext, DATA_WIDTH, PAR_TYP);
    end else if (r_state == ST_DATA && w_bit_end) begin
      r_shift  <= r_shift >> 1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_presc    <= PRESCALE_WIDTH'(1);
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      if (r_state != ST_IDLE) r_cnt <= w_bit_end ? '0 : r_cnt + PRESCALE_WIDTH'(1);
      // A pop starts a frame from IDLE or directly out of the last stop bit.
      if (w_pop) begin
        r_state    <= ST_START;
        r_tx       <= 1'b0;
        r_busy     <= 1'b1;
        r_cnt      <= '0;
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
        r_par_en   <= PAR_EN;
        r_stop2    <= STOP2;
        r_presc    <= (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
      end else if (w_bit_end) begin
        case (r_state)
          ST_START: begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
          end
          ST_DATA: begin
            if (r_bit_idx == BIT_LAST) begin
              r_state <= r_par_en ? ST_PARITY : ST_STOP;
              r_tx    <= r_par_en ? r_parity : 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + BW'(1);
              r_tx      <= r_shift[1];
            end
          end
          ST_PARITY: begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
          ST_STOP: begin
            if (w_last_stop) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_tx    <= 1'b1;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: reset, parity/stop variants,
// back-to-back frames, FIFO fill/backpressure and reset during a frame.
module tb_uart_tx_buffered;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] Prescale = 16'd4;
  logic        PAR_EN = 1'b0;
  logic        PAR_TYP = 1'b0;
  logic        STOP2 = 1'b0;
  logic [7:0]  S_DATA = 8'h00;
  logic        S_VALID = 1'b0;
  logic        S_READY;
  logic        TX_OUT;
  logic        Busy;
  logic [3:0]  FIFO_COUNT;

  int checks = 0;
  int failures = 0;

  logic       rx_en = 1'b0;
  logic [7:0] rxq [$];
  localparam int RXP = 100;

  uart_tx_buffered #(
    .DATA_WIDTH(8), .FIFO_DEPTH(8), .PRESCALE_WIDTH(16)
  ) dut (
    .CLK(CLK), .RST(RST), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP2(STOP2), .S_DATA(S_DATA), .S_VALID(S_VALID),
    .S_READY(S_READY), .TX_OUT(TX_OUT), .Busy(Busy), .FIFO_COUNT(FIFO_COUNT)
  );

  always #5 CLK = ~CLK;

  // Mid-bit sampling receiver, 8N1 at RXP cycles per bit.
  initial begin : rx_proc
    logic [7:0] rx_byte;
    forever begin
      @(posedge CLK); #1;
      if (rx_en && TX_OUT === 1'b0) begin
        repeat (RXP/2) begin @(posedge CLK); #1; end
        for (int b = 0; b < 8; b++) begin
          repeat (RXP) begin @(posedge CLK); #1; end
          rx_byte[b] = TX_OUT;
        end
        repeat (RXP) begin @(posedge CLK); #1; end
        rxq.push_back(rx_byte);
      end
    end
  end

  task automatic test_reset();
    @(posedge CLK); #1;
    checks++; if (TX_OUT !== 1'b1) begin failures++; $display("FAIL rst_tx_during got=%b exp=1", TX_OUT); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rst_busy_during got=%b exp=0", Busy); end
    checks++; if (S_READY !== 1'b1) begin failures++; $display("FAIL rst_ready_during got=%b exp=1", S_READY); end
    checks++; if (FIFO_COUNT !== 4'd0) begin failures++; $display("FAIL rst_count_during got=%0d exp=0", FIFO_COUNT); end
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    checks++; if (TX_OUT !== 1'b1) begin failures++; $display("FAIL rst_tx_after got=%b exp=1", TX_OUT); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rst_busy_after got=%b exp=0", Busy); end
    checks++; if (S_READY !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b exp=1", S_READY); end
    checks++; if (FIFO_COUNT !== 4'd0) begin failures++; $display("FAIL rst_count_after got=%0d exp=0", FIFO_COUNT); end
  endtask

  // Single frame: bits packed LSB-first (start, data, parity, stops).
  task automatic test_single(input string name, input logic [7:0] d, input logic pen,
                             input logic ptyp, input logic st2, input logic [15:0] exp_bits,
                             input int nbits);
    int errs;
    Prescale = 16'd4; PAR_EN = pen; PAR_TYP = ptyp; STOP2 = st2;
    @(negedge CLK); S_DATA = d; S_VALID = 1'b1;
    @(posedge CLK); #1; S_VALID = 1'b0;
    checks++; if (TX_OUT !== 1'b1) begin failures++; $display("FAIL %s_latency_tx got=%b exp=1", name, TX_OUT); end
    checks++; if (FIFO_COUNT !== 4'd1) begin failures++; $display("FAIL %s_count_push got=%0d exp=1", name, FIFO_COUNT); end
    @(posedge CLK); #1;
    errs = 0;
    for (int i = 0; i < nbits*4; i++) begin
      if (TX_OUT !== exp_bits[i/4] || Busy !== 1'b1) begin
        errs++;
        if (errs <= 3) $display("FAIL %s_wave cyc=%0d tx=%b busy=%b exp_tx=%b exp_busy=1", name, i, TX_OUT, Busy, exp_bits[i/4]);
      end
      @(posedge CLK); #1;
    end
    checks++; if (errs != 0) failures++;
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL %s_busy_end got=%b exp=0", name, Busy); end
    checks++; if (TX_OUT !== 1'b1) begin failures++; $display("FAIL %s_idle_tx got=%b exp=1", name, TX_OUT); end
  endtask

  task automatic test_back_to_back();
    logic [29:0] exp_bits;
    int errs;
    exp_bits = {1'b1, 8'h5A, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 8'h3C, 1'b0};
    Prescale = 16'd2; PAR_EN = 1'b0; STOP2 = 1'b0;
    @(negedge CLK); S_DATA = 8'h3C; S_VALID = 1'b1;
    @(posedge CLK); #1; S_DATA = 8'h81;
    @(posedge CLK); #1;
    errs = 0;
    fork
      begin
        S_DATA = 8'h5A;
        @(posedge CLK); #1; S_VALID = 1'b0;
      end
      begin
        for (int i = 0; i < 60; i++) begin
          if (TX_OUT !== exp_bits[i/2] || Busy !== 1'b1) begin
            errs++;
            if (errs <= 3) $display("FAIL b2b_wave cyc=%0d tx=%b busy=%b exp_tx=%b exp_busy=1", i, TX_OUT, Busy, exp_bits[i/2]);
          end
          @(posedge CLK); #1;
        end
      end
    join
    checks++; if (errs != 0) failures++;
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b exp=0", Busy); end
    checks++; if (FIFO_COUNT !== 4'd0) begin failures++; $display("FAIL b2b_count_end got=%0d exp=0", FIFO_COUNT); end
  endtask

  task automatic test_reset_mid_frame();
    int errs;
    Prescale = 16'd4; PAR_EN = 1'b0; STOP2 = 1'b0;
    @(negedge CLK); S_DATA = 8'h00; S_VALID = 1'b1;
    @(posedge CLK); #1; S_DATA = 8'h11;
    @(posedge CLK); #1; S_DATA = 8'h22;
    @(posedge CLK); #1; S_DATA = 8'h33;
    @(posedge CLK); #1; S_VALID = 1'b0;
    checks++; if (FIFO_COUNT !== 4'd3) begin failures++; $display("FAIL midrst_count_pre got=%0d exp=3", FIFO_COUNT); end
    repeat (4) @(posedge CLK); #1;
    checks++; if (TX_OUT !== 1'b0) begin failures++; $display("FAIL midrst_data_bit got=%b exp=0", TX_OUT); end
    #2 RST = 1'b0; #1;
    checks++; if (TX_OUT !== 1'b1) begin failures++; $display("FAIL midrst_tx got=%b exp=1", TX_OUT); end
    checks++; if (FIFO_COUNT !== 4'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", FIFO_COUNT); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", Busy); end
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1'b1;
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK); #1;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0 || FIFO_COUNT !== 4'd0) errs++;
    end
    checks++; if (errs != 0) begin failures++; $display("FAIL midrst_quiet bad_cycles=%0d exp=0", errs); end
    @(negedge CLK); S_DATA = 8'h55; S_VALID = 1'b1;
    @(posedge CLK); #1; S_VALID = 1'b0;
    @(posedge CLK); #1;
    checks++; if (TX_OUT !== 1'b0 || Busy !== 1'b1) begin failures++; $display("FAIL midrst_restart tx=%b busy=%b exp tx=0 busy=1", TX_OUT, Busy); end
    repeat (45) @(posedge CLK); #1;
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL midrst_restart_end got=%b exp=0", Busy); end
  endtask

  task automatic test_fifo_fill();
    logic [7:0] w [10];
    int acc_cyc [10];
    int idx;
    int wait_cyc;
    logic acc;
    w = '{8'hC1, 8'h52, 8'hE3, 8'h14, 8'hA5, 8'h36, 8'hF7, 8'h08, 8'h99, 8'h6A};
    for (int i = 0; i < 10; i++) acc_cyc[i] = -1;
    Prescale = 16'd100; PAR_EN = 1'b0; STOP2 = 1'b0;
    rxq.delete();
    rx_en = 1'b1;
    idx = 0;
    for (int c = 0; c < 1100 && idx < 10; c++) begin
      @(negedge CLK); S_DATA = w[idx]; S_VALID = 1'b1; acc = S_READY;
      @(posedge CLK);
      if (acc) begin acc_cyc[idx] = c; idx++; end
      #1;
      if (c == 8) begin
        checks++; if (FIFO_COUNT !== 4'd8) begin failures++; $display("FAIL fill_count got=%0d exp=8", FIFO_COUNT); end
        checks++; if (S_READY !== 1'b0) begin failures++; $display("FAIL fill_ready_low got=%b exp=0", S_READY); end
      end
    end
    @(negedge CLK); S_VALID = 1'b0;
    checks++; if (idx != 10) begin failures++; $display("FAIL fill_accepted got=%0d exp=10", idx); end
    for (int i = 0; i < 9; i++) begin
      checks++; if (acc_cyc[i] != i) begin failures++; $display("FAIL fill_acc_cycle word=%0d got=%0d exp=%0d", i, acc_cyc[i], i); end
    end
    checks++; if (acc_cyc[9] != 1002) begin failures++; $display("FAIL fill_acc_cycle word=9 got=%0d exp=1002", acc_cyc[9]); end
    wait_cyc = 0;
    while (rxq.size() < 10 && wait_cyc < 12000) begin @(posedge CLK); wait_cyc++; end
    rx_en = 1'b0;
    checks++; if (rxq.size() != 10) begin failures++; $display("FAIL fill_rx_count got=%0d exp=10", rxq.size()); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= rxq.size()) begin failures++; $display("FAIL fill_order word=%0d got=none exp=%h", i, w[i]); end
      else if (rxq[i] !== w[i]) begin failures++; $display("FAIL fill_order word=%0d got=%h exp=%h", i, rxq[i], w[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single("even_a5", 8'hA5, 1'b1, 1'b0, 1'b0, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11);
    test_single("odd_07", 8'h07, 1'b1, 1'b1, 1'b1, {4'b0, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 12);
    test_back_to_back();
    test_reset_mid_frame();
    test_fifo_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised UART transmitter with an internal transmit FIFO, an integrated baud divider, configurable parity and 1 or 2 stop bits. It sits where the bare transmitter sat inside the UART top level. It accepts words over a valid/ready handshake, buffers up to FIFO_DEPTH of them, and serialises them back-to-back on TX_OUT with no idle gap between frames.

## Interface
- DATA_WIDTH, 8: bits per character, range 5..9.
- FIFO_DEPTH, 8: buffer entries; must be a power of 2, at least 2.
- PRESCALE_WIDTH, 16: width of the Prescale input.
- CLK  input  1  system clock; all logic runs on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- Prescale  input  PRESCALE_WIDTH  CLK cycles per bit; the value 0 is treated as 1.
- PAR_EN  input  1  1 = append a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- STOP2  input  1  1 = two stop bits, 0 = one.
- S_DATA  input  DATA_WIDTH  word to transmit.
- S_VALID  input  1  S_DATA is valid.
- S_READY  output  1  FIFO can accept a word; equals !full.
- TX_OUT  output  1  serial line; idles high.
- Busy  output  1  a frame is in progress (FSM not in IDLE).
- FIFO_COUNT  output  $clog2(FIFO_DEPTH)+1  number of words currently buffered.

## Operation
- **Write:** a word is written when S_VALID && S_READY at a rising edge. S_VALID while S_READY is low has no effect. No overflow is possible.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. On the same edge the head word is popped into the shift register, and PAR_EN, PAR_TYP, STOP2 and Prescale are latched for the frame.
  - START → DATA after 1 bit time.
  - DATA shifts LSB first for DATA_WIDTH bit times, then goes to PARITY if latched PAR_EN, otherwise to STOP.
  - PARITY → STOP after 1 bit time.
  - STOP lasts 1 or 2 bit times. It then goes to START with an immediate pop if the FIFO is non-empty, otherwise to IDLE.
- **Parity bit:** ^data for even, ~^data for odd.
- **TX_OUT level per state:** IDLE 1, START 0, DATA current bit, PARITY parity bit, STOP 1. TX_OUT is registered.
- **Bit time counter:** counts 0..Prescale_latched−1, then wraps; a bit ends on the wrap.
- **Frame length:** Prescale × (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) cycles.
- **Mid-frame input changes:** changes to Prescale, PAR_EN, PAR_TYP or STOP2 affect only the next frame.
- **Simultaneous push and pop:** FIFO_COUNT is unchanged. A push into an empty FIFO while the FSM is idle is popped on the next edge, not the same edge.
- **FIFO full:** S_READY is low. It rises in the cycle after a pop.
- **Reset (asserted any time, including mid-frame):** FIFO flushed (FIFO_COUNT 0), FSM in IDLE, counters cleared.

## Timing
- **Reset values:** TX_OUT 1, Busy 0, S_READY 1, FIFO_COUNT 0.
- **Acceptance to start bit:** a word accepted at edge k into an empty FIFO with the FSM idle pops at edge k+1. TX_OUT goes low and Busy goes high after edge k+1, so latency is 1 cycle.
- **FIFO_COUNT:** updates on the edge after the push or pop.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the last stop-bit cycle. Busy stays high across the boundary.
- **Frame end:** Busy falls on the edge that ends the final stop bit when the FIFO is empty.

## Structure
- **Shared package uart_pkg:** the FSM state enum, the parity encoding constants (PAR_EVEN=0, PAR_ODD=1), and a function computing parity over DATA_WIDTH bits.
- **Sub-module uart_sync_fifo:** the buffer, parametrised by width and depth. It has full, empty and count outputs and a pointer-plus-wrap-bit scheme.
- **Top module:** contains the FSM, bit time counter, bit index counter and shift register.

## Test plan
- **Reset state:** RST low for 3 cycles, then high → TX_OUT=1, Busy=0, S_READY=1, FIFO_COUNT=0 while RST is low and after release.
- **Single frame, even parity:** DATA_WIDTH=8, Prescale=4, PAR_EN=1, PAR_TYP=0, STOP2=0, send 0xA5 → start bit 1 cycle after acceptance. Each bit lasts 4 cycles, with data 1,0,1,0,0,1,0,1, parity 0 and stop 1, for 44 cycles total. Busy falls after 44.
- **Odd parity, two stop bits:** same settings with PAR_TYP=1, STOP2=1, send 0x07 → parity bit 0, two stop bits, 48 cycles.
- **Back-to-back frames:** three words queued with PAR_EN=0, Prescale=2 → three 20-cycle frames with no gap between them. Busy stays high for 60 cycles.
- **FIFO fill:** Prescale=100, S_VALID held high with 10 distinct words, FIFO_DEPTH=8 → 9 words accepted on consecutive edges (the first is popped immediately). S_READY falls after the 9th and the 10th is held until the first frame ends. Words transmit in order.
- **Reset mid-frame:** RST asserted during the DATA state with 3 words buffered → TX_OUT=1 immediately and FIFO_COUNT=0. After release, no frame is sent until a new write.
